cordic_arb: RTL and testbench
=============================

# cordic_arb

Round-robin arbiter and sequencer that shares one `cordic_12b` pipelined CORDIC core among `NREQ` requesters. It accepts one angle/vector per cycle from the granted requester and registers it into the core. A tag delay line matched to the core latency returns each sin/cos result to the requester that issued it. A pause/drain state machine lets the system quiesce the core, for example before gating it or reconfiguring the requesters.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `WIDTH`, 12: data width. Must match the core.
- `CORE_LAT`, 13: core latency in cycles, from input sample to `SINout`/`COSout` valid.
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high. The core's `resetn` is driven from `~reset`.
- `req_valid`, in, NREQ: per-requester request.
- `req_ready`, out, NREQ: one-hot grant. Combinational from `req_valid`, the RR pointer and the state.
- `req_angle`, in, NREQ*WIDTH: flattened; requester i uses bits [i*WIDTH +: WIDTH]. Full circle maps to 0..2^WIDTH-1.
- `req_x`, `req_y`, in, NREQ*WIDTH: flattened start vectors.
- `rsp_valid`, out, NREQ: one-hot, single-cycle result strobe. There is no backpressure.
- `rsp_sin`, `rsp_cos`, out, WIDTH signed: shared result bus. Valid only while some `rsp_valid` bit is high.
- `pause`, in, 1: level. Request to stop granting and drain.
- `idle`, out, 1: high in PAUSED with an empty pipeline.
- `inflight`, out, 5: number of accepted, not-yet-returned transactions.

## Operation
**States and transitions**
- RUN → DRAIN when `pause`=1.
- DRAIN → PAUSED when `inflight`=0 and `pause`=1.
- DRAIN → RUN when `pause`=0.
- PAUSED → RUN when `pause`=0.
- Reset state is RUN.

**Grants**
- Grants are issued only in RUN, at most one per cycle.
- Round-robin search starts at `rr_ptr`. After each handshake, `rr_ptr` = granted index + 1, mod NREQ. Without a handshake, `rr_ptr` holds.
- A handshake is `req_valid[i] & req_ready[i]`.

**Core input**
- On a handshake, the granted angle, x and y are registered into the core-input registers.
- A tag {valid=1, id=i} enters the delay line on the same edge.
- With no handshake, the core inputs hold their previous values and a tag with valid=0 enters. The core computes on stale data, but its results are dropped.

**Delay line and results**
- Delay line depth is CORE_LAT+1: one stage for the input register plus CORE_LAT.
- At its output, `rsp_valid[id]` = tag.valid, and `rsp_sin`/`rsp_cos` = core `SINout`/`COSout`.

**`inflight` and boundary cases**
- `inflight` increments on a handshake and decrements on a returning valid tag. A simultaneous increment and decrement leaves it unchanged.
- `inflight` never exceeds CORE_LAT+1, so it cannot overflow.
- `pause` asserted in the same cycle as a request: no grant that cycle, because the state is evaluated combinationally from `pause`.
- Reset mid-operation clears all in-flight tags. No `rsp_valid` is emitted afterwards for transactions accepted before reset.

## Timing
- Handshake in cycle t → `rsp_valid` high in cycle t+CORE_LAT+1 (t+14 by default).
- Full throughput: one result per cycle when requests are back-to-back.
- Outputs during and after reset:
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_sin` = `rsp_cos` = 0.
  - `inflight` = 0, `idle` = 0, `rr_ptr` = 0, all tags invalid.
  - Core input registers = 0.
- `idle` rises in the cycle after the last result returns while `pause` is held. It drops in the cycle after `pause` falls.

## Configuration
- `CORDIC_ARB_FIXED_PRIO_EN` defined: fixed priority. The lowest index wins and `rr_ptr` is removed.
- Not defined: round-robin as described above.
- All other behaviour and timing are identical in both builds.

## Structure
- Shared package `cordic_pkg`:
  - `CORDIC_WIDTH` = 12
  - `CORDIC_LAT` = 13
  - arbiter state enum {RUN, DRAIN, PAUSED}
  - tag struct {valid, id[2:0]}
- Sub-module `cordic_tag_pipe`: parameterized-depth shift register of tags with synchronous clear.
- `cordic_arb` instantiates `cordic_tag_pipe` and `cordic_12b`.

## Test plan
- **Single request.** Requester 0 sends angle=0, x=1243, y=0 at cycle 5 → `rsp_valid`=4'b0001 at cycle 19, `rsp_cos`≈2047 ±4, `rsp_sin`≈0 ±4.
- **Quadrant 01.** Requester 2 sends angle=12'h400 (π/2), x=1243, y=0 → `rsp_valid`[2] 14 cycles later, `rsp_sin`≈2047 ±4, `rsp_cos`≈0 ±4.
- **Round-robin fairness.** All four `req_valid` held high for 8 cycles → grants in order 0,1,2,3,0,1,2,3. Results return in the same order, one per cycle. `inflight` peaks at 8.
- **Drain.** Issue 3 requests, then assert `pause` → no further `req_ready`. All 3 results are delivered, then `idle`=1. Deassert `pause` → `idle`=0 next cycle and grants resume.
- **Reset mid-flight.** Assert `reset` 5 cycles after a handshake → no `rsp_valid` for that transaction, and `inflight`=0 after reset.
- **Fixed-priority build.** With the macro defined and all four requesters valid → requester 0 is granted every cycle.

Source files
------------

// File: rtl/cordic_pkg.sv
// cordic_pkg: definitions shared by the CORDIC core, the tag delay line and the
// requester arbiter.
//   CORDIC_WIDTH : sample width of angle, start vector and results
//   CORDIC_LAT   : core latency in cycles, input sample to SINout/COSout
//   CORDIC_ITER  : number of micro-rotation stages in the core
//   arb_state_t  : arbiter state (RUN, DRAIN, PAUSED)
//   cordic_tag_t : tag travelling beside the core pipeline {valid, id}
//   cordic_atan  : arctan(2^-i) in units of 2^16 per full turn
package cordic_pkg;

    localparam int CORDIC_WIDTH = 12;
    localparam int CORDIC_LAT   = 13;
    localparam int CORDIC_ITER  = 12;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        PAUSED
    } arb_state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] id;
    } cordic_tag_t;

    function automatic logic signed [16:0] cordic_atan(input int i);
        case (i)
            0:       return 17'sd8192;
            1:       return 17'sd4836;
            2:       return 17'sd2555;
            3:       return 17'sd1297;
            4:       return 17'sd651;
            5:       return 17'sd326;
            6:       return 17'sd163;
            7:       return 17'sd81;
            8:       return 17'sd41;
            9:       return 17'sd20;
            10:      return 17'sd10;
            11:      return 17'sd5;
            default: return 17'sd0;
        endcase
    endfunction

endpackage

// File: rtl/cordic_12b.sv
// cordic_12b: fully pipelined rotation-mode CORDIC. Rotates (Xin, Yin) by
// angle (full turn = 2^12) and returns the rotated vector scaled by the
// CORDIC gain (~1.6468); Xin=1243, Yin=0 yields a full-scale cos/sin.
// One quadrant pre-rotation stage plus CORDIC_ITER micro-rotations give a
// latency of CORDIC_LAT cycles from input sample to output.
//   clk    : clock, rising edge
//   resetn : synchronous, active-low; clears the whole pipeline
//   angle  : unsigned angle
//   Xin    : signed start vector x
//   Yin    : signed start vector y
//   SINout : signed rotated y, saturated
//   COSout : signed rotated x, saturated
module cordic_12b
    import cordic_pkg::*;
(
    input  logic                           clk,
    input  logic                           resetn,
    input  logic        [CORDIC_WIDTH-1:0] angle,
    input  logic signed [CORDIC_WIDTH-1:0] Xin,
    input  logic signed [CORDIC_WIDTH-1:0] Yin,
    output logic signed [CORDIC_WIDTH-1:0] SINout,
    output logic signed [CORDIC_WIDTH-1:0] COSout
);

    // Guard bits keep shift truncation well below one output LSB; the two
    // extra integer bits cover the sqrt(2) * gain growth of the vector.
    localparam int GUARD = 4;
    localparam int XW    = CORDIC_WIDTH + GUARD + 2;
    localparam int ZW    = 17;

    localparam logic signed [XW:0] HALF    = (XW+1)'(1 << (GUARD - 1));
    localparam logic signed [XW:0] OUT_MAX = (XW+1)'((1 << (CORDIC_WIDTH - 1)) - 1);
    localparam logic signed [XW:0] OUT_MIN = -OUT_MAX - (XW+1)'(1);

    logic signed [XW-1:0] xs [0:CORDIC_ITER];
    logic signed [XW-1:0] ys [0:CORDIC_ITER];
    logic signed [ZW-1:0] zs [0:CORDIC_ITER-1];

    logic signed [XW-1:0] xe, ye, x_rot, y_rot;
    logic signed [ZW-1:0] z_res;

    assign xe = XW'(Xin) <<< GUARD;
    assign ye = XW'(Yin) <<< GUARD;

    // The top two angle bits pick a quadrant, removed exactly by a 90-degree
    // swap/negate; only the residual 0..90 degrees goes through the iterations.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves an output
        // unassigned, which would otherwise infer a latch.
        x_rot = xe;
        y_rot = ye;
        unique case (angle[CORDIC_WIDTH-1 -: 2])
            2'd0: begin x_rot = xe;  y_rot = ye;  end
            2'd1: begin x_rot = -ye; y_rot = xe;  end
            2'd2: begin x_rot = -xe; y_rot = -ye; end
            2'd3: begin x_rot = ye;  y_rot = -xe; end
            default: ;
        endcase
    end

    // Residual angle rescaled to 2^16 units per full turn.
    assign z_res = {3'b000, angle[CORDIC_WIDTH-3:0], 4'b0000};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int s = 0; s <= CORDIC_ITER; s++) begin
                xs[s] <= '0;
                ys[s] <= '0;
            end
            for (int s = 0; s < CORDIC_ITER; s++) begin
                zs[s] <= '0;
            end
        end else begin
            xs[0] <= x_rot;
            ys[0] <= y_rot;
            zs[0] <= z_res;
            for (int s = 1; s <= CORDIC_ITER; s++) begin
                if (!zs[s-1][ZW-1]) begin
                    xs[s] <= xs[s-1] - (ys[s-1] >>> (s - 1));
                    ys[s] <= ys[s-1] + (xs[s-1] >>> (s - 1));
                end else begin
                    xs[s] <= xs[s-1] + (ys[s-1] >>> (s - 1));
                    ys[s] <= ys[s-1] - (xs[s-1] >>> (s - 1));
                end
            end
            // The last stage has no successor, so its residual is not kept.
            for (int s = 1; s < CORDIC_ITER; s++) begin
                if (!zs[s-1][ZW-1]) begin
                    zs[s] <= zs[s-1] - cordic_atan(s - 1);
                end else begin
                    zs[s] <= zs[s-1] + cordic_atan(s - 1);
                end
            end
        end
    end

    function automatic logic signed [CORDIC_WIDTH-1:0] sat_round(input logic signed [XW-1:0] v);
        logic signed [XW:0] t;
        t = (XW+1)'(v);
        t = (t + HALF) >>> GUARD;
        if (t > OUT_MAX) return OUT_MAX[CORDIC_WIDTH-1:0];
        if (t < OUT_MIN) return OUT_MIN[CORDIC_WIDTH-1:0];
        return t[CORDIC_WIDTH-1:0];
    endfunction

    assign SINout = sat_round(ys[CORDIC_ITER]);
    assign COSout = sat_round(xs[CORDIC_ITER]);

endmodule

// File: rtl/cordic_tag_pipe.sv
// cordic_tag_pipe: fixed-depth shift register of request tags that runs beside
// the CORDIC pipeline, so every result leaves together with the id of the
// requester that issued it.
//   clk     : clock, rising edge
//   clr     : synchronous clear, empties every stage
//   tag_in  : tag entering this cycle
//   tag_out : tag DEPTH cycles old
module cordic_tag_pipe
    import cordic_pkg::*;
#(
    parameter int DEPTH = CORDIC_LAT + 1
) (
    input  logic        clk,
    input  logic        clr,
    input  cordic_tag_t tag_in,
    output cordic_tag_t tag_out
);

    cordic_tag_t stage [DEPTH];

    always_ff @(posedge clk) begin
        // NOTE: every stage is cleared, not just the head: a surviving valid
        // tag would emit a response for a transaction that reset discarded.
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments let every stage sample its
            // neighbour's old value, which is what makes this a shift register.
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/cordic_arb.sv
// cordic_arb: shares one cordic_12b among NREQ requesters. One request per
// cycle is granted, registered into the core, and its requester id travels
// down a tag line matched to the core latency so the result is returned to
// the right requester. pause drains the core and reports idle when empty.
// Build option: CORDIC_ARB_FIXED_PRIO_EN selects fixed priority (lowest index
// wins, no round-robin pointer); default is round-robin.
//   clk, reset            : clock; synchronous active-high reset
//   req_valid / req_ready : per-requester request / one-hot grant
//   req_angle, req_x,
//   req_y                 : flattened, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid             : one-hot single-cycle result strobe
//   rsp_sin, rsp_cos      : shared result bus
//   pause                 : level request to stop granting and drain
//   idle                  : paused with an empty pipeline
//   inflight              : accepted, not yet returned transactions
module cordic_arb
    import cordic_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int WIDTH    = CORDIC_WIDTH,
    parameter int CORE_LAT = CORDIC_LAT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_angle,
    input  logic [NREQ*WIDTH-1:0]   req_x,
    input  logic [NREQ*WIDTH-1:0]   req_y,
    output logic [NREQ-1:0]         rsp_valid,
    output logic signed [WIDTH-1:0] rsp_sin,
    output logic signed [WIDTH-1:0] rsp_cos,
    input  logic                    pause,
    output logic                    idle,
    output logic [4:0]              inflight
);

    arb_state_t  state_q, state_d;
    logic [2:0]  grant_id;
    logic        grant_en;
    logic        hs;
    logic        ret;
    logic        drain_empty;
    cordic_tag_t tag_in, tag_out;

    logic        [WIDTH-1:0] angle_q;
    logic signed [WIDTH-1:0] x_q, y_q;

`ifndef CORDIC_ARB_FIXED_PRIO_EN
    localparam int PW = $clog2(NREQ);
    logic [PW-1:0] rr_ptr;
`endif

    // Every state moves to RUN when pause is low, so "next state is RUN"
    // reduces to !pause; this also keeps the grant free of any path through
    // inflight, avoiding a loop.
    assign grant_en = !reset && !pause;

    always_comb begin
        req_ready = '0;
        grant_id  = '0;
`ifdef CORDIC_ARB_FIXED_PRIO_EN
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) grant_id = 3'(i);
        end
`else
        // Scan backwards from the farthest slot so the requester closest to
        // rr_ptr is the last (winning) assignment.
        for (int k = NREQ - 1; k >= 0; k--) begin
            int idx;
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req_valid[idx]) grant_id = 3'(idx);
        end
`endif
        if (grant_en && (|req_valid)) begin
            req_ready = NREQ'(1) << grant_id;
        end
    end

    assign hs  = |(req_valid & req_ready);
    assign ret = tag_out.valid;

    // In DRAIN nothing is granted, so the pipeline is empty after this edge
    // exactly when the only outstanding transaction (if any) returns now.
    assign drain_empty = (inflight == 5'(ret));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (pause) state_d = DRAIN;
            DRAIN:   if (!pause) state_d = RUN;
                     else if (drain_empty) state_d = PAUSED;
            PAUSED:  if (!pause) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            inflight <= '0;
            angle_q  <= '0;
            x_q      <= '0;
            y_q      <= '0;
`ifndef CORDIC_ARB_FIXED_PRIO_EN
            rr_ptr   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            inflight <= inflight + 5'(hs) - 5'(ret);
            if (hs) begin
                angle_q <= req_angle[grant_id*WIDTH +: WIDTH];
                x_q     <= req_x[grant_id*WIDTH +: WIDTH];
                y_q     <= req_y[grant_id*WIDTH +: WIDTH];
`ifndef CORDIC_ARB_FIXED_PRIO_EN
                rr_ptr  <= (int'(grant_id) == NREQ - 1) ? '0 : PW'(grant_id + 3'd1);
`endif
            end
        end
    end

    // Without a handshake the core keeps computing on the held inputs; the
    // invalid tag marks those results for dropping.
    assign tag_in.valid = hs;
    assign tag_in.id    = hs ? grant_id : 3'd0;

    // One stage for the core-input register plus the core latency.
    cordic_tag_pipe #(
        .DEPTH(CORE_LAT + 1)
    ) u_tag_pipe (
        .clk     (clk),
        .clr     (reset),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    cordic_12b u_core (
        .clk    (clk),
        .resetn (~reset),
        .angle  (angle_q),
        .Xin    (x_q),
        .Yin    (y_q),
        .SINout (rsp_sin),
        .COSout (rsp_cos)
    );

    assign rsp_valid = tag_out.valid ? (NREQ'(1) << tag_out.id) : '0;
    assign idle      = (state_q == PAUSED) && (inflight == 5'd0);

endmodule

// File: tb/tb_cordic_arb.sv
`timescale 1ns/1ps
module tb_cordic_arb;

    localparam int NREQ = 4;
    localparam int W    = 12;
    localparam int LAT  = 13;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*W-1:0]     req_angle, req_x, req_y;
    logic [NREQ-1:0]       rsp_valid;
    logic signed [W-1:0]   rsp_sin, rsp_cos;
    logic                  pause;
    logic                  idle;
    logic [4:0]            inflight;

    always #5 clk = ~clk;

    cordic_arb #(.NREQ(NREQ), .WIDTH(W), .CORE_LAT(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_angle (req_angle),
        .req_x     (req_x),
        .req_y     (req_y),
        .rsp_valid (rsp_valid),
        .rsp_sin   (rsp_sin),
        .rsp_cos   (rsp_cos),
        .pause     (pause),
        .idle      (idle),
        .inflight  (inflight)
    );

    typedef struct {
        int id;
        int due;
        int sin_v;
        int cos_v;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   exp_rr   = 0;
    int   peak_inflight = 0;
    int   last_rsp_cyc  = -1;

    task automatic check(input string tag, input int obs, input int exp, input int tol = 0);
        n_checks++;
        if (obs > exp + tol || obs < exp - tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d) at cycle %0d", tag, obs, exp, tol, cyc);
        end
    endtask

    // Ideal rotation of (x, y) by ang (full turn = 4096), times the CORDIC gain.
    function automatic int model_rot(input bit want_sin, input int ang, input int x, input int y);
        real th, v;
        int  r;
        th = real'(ang) * 2.0 * 3.14159265358979 / 4096.0;
        if (want_sin) v = 1.6467602581 * (real'(x) * $sin(th) + real'(y) * $cos(th));
        else          v = 1.6467602581 * (real'(x) * $cos(th) - real'(y) * $sin(th));
        r = $rtoi(v + ((v >= 0.0) ? 0.5 : -0.5));
        if (r > 2047)  r = 2047;
        if (r < -2048) r = -2048;
        return r;
    endfunction

    function automatic int model_pick(input logic [NREQ-1:0] v, input int ptr);
        int p;
        p = ptr;
`ifdef CORDIC_ARB_FIXED_PRIO_EN
        p = 0;
`endif
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return 1 << ((p + k) % NREQ);
        end
        return 0;
    endfunction

    always @(posedge clk) cyc++;

    // Monitor / scoreboard, sampled on the falling edge.
    exp_t                mon_e;
    logic [NREQ-1:0]     mon_hs;
    int                  mon_gid;
    logic signed [W-1:0] mon_x, mon_y;

    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            exp_rr = 0;
        end else begin
            check("inflight", int'(inflight), sb.size());
            if (int'(inflight) > peak_inflight) peak_inflight = int'(inflight);
            if (req_ready != '0) check("rr_pick", int'(req_ready), model_pick(req_valid, exp_rr));
            if (rsp_valid != '0) begin
                last_rsp_cyc = cyc;
                if (sb.size() == 0) begin
                    check("rsp_unexpected", int'(rsp_valid), 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("rsp_id",    int'(rsp_valid), 1 << mon_e.id);
                    check("rsp_cycle", cyc, mon_e.due);
                    check("rsp_sin",   int'(rsp_sin), mon_e.sin_v, 4);
                    check("rsp_cos",   int'(rsp_cos), mon_e.cos_v, 4);
                end
            end
            mon_hs = req_valid & req_ready;
            if (mon_hs != '0) begin
                mon_gid = 0;
                for (int i = 0; i < NREQ; i++) if (mon_hs[i]) mon_gid = i;
                mon_x = req_x[mon_gid*W +: W];
                mon_y = req_y[mon_gid*W +: W];
                mon_e.id    = mon_gid;
                mon_e.due   = cyc + LAT + 1;
                mon_e.sin_v = model_rot(1'b1, int'(req_angle[mon_gid*W +: W]), int'(mon_x), int'(mon_y));
                mon_e.cos_v = model_rot(1'b0, int'(req_angle[mon_gid*W +: W]), int'(mon_x), int'(mon_y));
                sb.push_back(mon_e);
                exp_rr = (mon_gid + 1) % NREQ;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input int a, input int x, input int y);
        req_angle[i*W +: W] = W'(a);
        req_x[i*W +: W]     = W'(x);
        req_y[i*W +: W]     = W'(y);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_timeout", sb.size(), 0);
        tick();
        tick();
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    int t_hs;
    int first_idle;

    // Single requests: {requester, angle, x, y}
    int pat [4][4] = '{
        '{1, 12'h200,  1000,  200},
        '{3, 12'hA00,  -800,  500},
        '{0, 12'hC80,   600, -900},
        '{2, 12'h7FF, -1200,    0}
    };

    initial begin
        reset     = 1'b1;
        pause     = 1'b0;
        req_valid = '1;
        req_angle = '0;
        req_x     = '0;
        req_y     = '0;
        repeat (3) tick();

        // Outputs held in reset, even with requests pending.
        @(negedge clk);
        check("reset_req_ready", int'(req_ready), 0);
        check("reset_rsp_valid", int'(rsp_valid), 0);
        check("reset_rsp_sin",   int'(rsp_sin), 0);
        check("reset_rsp_cos",   int'(rsp_cos), 0);
        check("reset_inflight",  int'(inflight), 0);
        check("reset_idle",      int'(idle), 0);
        tick();
        reset     = 1'b0;
        req_valid = '0;
        repeat (3) tick();
        @(negedge clk);
        check("post_reset_sin",  int'(rsp_sin), 0);
        check("post_reset_cos",  int'(rsp_cos), 0);
        check("post_reset_idle", int'(idle), 0);
        tick();

        // Round-robin fairness from reset: all requesters valid for 8 cycles.
        set_req(0, 12'h123,  1100, -300);
        set_req(1, 12'h5A0,  -700,  600);
        set_req(2, 12'h9C4,   900,  200);
        set_req(3, 12'hE10,   300, -1000);
        peak_inflight = 0;
        req_valid = '1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rr_order", int'(req_ready), 1 << (i % NREQ));
            tick();
        end
        req_valid = '0;
        wait_drain(40);
        check("inflight_peak", peak_inflight, 8);

        // Single request, angle 0.
        set_req(0, 0, 1243, 0);
        req_valid = 4'b0001;
        @(negedge clk);
        check("single_ready", int'(req_ready), 1);
        t_hs = cyc;
        tick();
        req_valid = '0;
        wait_cyc(t_hs + 14);
        check("single_rsp_valid", int'(rsp_valid), 1);
        check("single_cos", int'(rsp_cos), 2047, 4);
        check("single_sin", int'(rsp_sin), 0, 4);
        tick();
        wait_drain(30);

        // Quadrant 01: pi/2 from requester 2.
        set_req(2, 12'h400, 1243, 0);
        req_valid = 4'b0100;
        @(negedge clk);
        check("quad_ready", int'(req_ready), 4);
        t_hs = cyc;
        tick();
        req_valid = '0;
        wait_cyc(t_hs + 14);
        check("quad_rsp_valid", int'(rsp_valid), 4);
        check("quad_sin", int'(rsp_sin), 2047, 4);
        check("quad_cos", int'(rsp_cos), 0, 4);
        tick();
        wait_drain(30);

        // Assorted angles and vectors, back to back from different requesters.
        for (int p = 0; p < 4; p++) begin
            set_req(pat[p][0], pat[p][1], pat[p][2], pat[p][3]);
            req_valid = NREQ'(1) << pat[p][0];
            tick();
        end
        req_valid = '0;
        wait_drain(40);

        // Drain: three requests, then pause together with new requests.
        for (int i = 0; i < 3; i++) begin
            set_req(i, 300 * (i + 1), 800 - 300 * i, 150 * i);
            req_valid = NREQ'(1) << i;
            tick();
        end
        pause      = 1'b1;
        req_valid  = '1;
        first_idle = -1;
        for (int n = 0; n < 40 && first_idle < 0; n++) begin
            @(negedge clk);
            check("drain_no_grant", int'(req_ready), 0);
            if (idle) first_idle = cyc;
            tick();
        end
        check("drain_all_returned", sb.size(), 0);
        check("idle_timing", first_idle, last_rsp_cyc + 1);
        tick();
        @(negedge clk);
        check("idle_hold", int'(idle), 1);
        check("paused_no_grant", int'(req_ready), 0);
        tick();
        pause = 1'b0;
        tick();
        @(negedge clk);
        check("resume_idle", int'(idle), 0);
        check("resume_grant", int'(req_ready != '0), 1);
        tick();
        req_valid = '0;
        wait_drain(40);

        // Reset five cycles after a handshake kills the transaction.
        set_req(3, 12'h321, 900, 400);
        req_valid = 4'b1000;
        @(negedge clk);
        check("midrst_ready", int'(req_ready), 8);
        tick();
        req_valid = '0;
        repeat (4) tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        @(negedge clk);
        check("midrst_inflight", int'(inflight), 0);
        tick();
        repeat (20) tick();
        @(negedge clk);
        check("midrst_quiet", int'(rsp_valid), 0);
        tick();

        // Round-robin pointer restarts at 0 after reset.
        req_valid = '1;
        @(negedge clk);
        check("rr_after_reset", int'(req_ready), 1);
        tick();
        req_valid = '0;
        wait_drain(30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
